point_accum_act: RTL and testbench
==================================

Name: point_accum_act

Overview:
- Downstream neighbour of the pointwise address controller.
- Receives the per-cycle 16-lane partial sums that the PE array produces from the controller's data/weight reads.
- Accumulates them over the filter's channel groups, then adds bias, requantizes to int8 and applies the MobileNetV3 activation.
- Its act_valid output drives the controller's activation_function_enable, so each output pixel increments the write address exactly once.

Parameters:
- LANES, 16, output filters processed in parallel (one lane per filter).
- PSUM_W, 24, signed width of each incoming lane partial sum.
- ACC_W, 32, signed accumulator width.
- BIAS_W, 32, signed bias width per lane.
- SIX_Q, 96, quantized value of 6.0 used by ReLU6/hswish (Q4 default).
- INV_SIX, 683, round(65536/SIX_Q); hswish reciprocal.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches config, clears state and overflow flag.
- channel_groups  in  4  channel groups per pixel (1..6); 0 treated as 1.
- act_mode  in  2  activation: 0 none, 1 ReLU, 2 ReLU6, 3 hswish.
- bias_in  in  LANES*BIAS_W  per-lane bias; sampled on each pixel completion.
- scale_in  in  16  unsigned requant multiplier; latched at start.
- shift_in  in  5  requant right shift (1..31); latched at start.
- psum_valid  in  1  partial-sum beat valid.
- psum_in  in  LANES*PSUM_W  signed partial sums, lane 0 in the LSBs.
- layer_end  in  1  pulse from the controller's Point_End.
- act_valid  out  1  one-cycle pulse per completed pixel (= activation_function_enable).
- act_data  out  LANES*8  signed int8 results.
- busy  out  1  high from start until drain completes.
- done  out  1  one-cycle pulse when the final result has been issued.
- sat_flag  out  1  sticky; set on any requant saturation.

Behaviour:
- Reset: all outputs 0; ch_cnt = 0; accumulators 0; pipeline valids 0; config registers 0.
- Reset mid-operation: immediate clear, in-flight results dropped, no act_valid.
- start:
  - Latches channel_groups (0 becomes 1), act_mode, scale_in, shift_in.
  - Sets busy; clears sat_flag and ch_cnt.
  - A psum_valid in the same cycle is ignored.
  - start while busy restarts: pipeline flushed, no act_valid for in-flight data.
- Accumulate (stage A):
  - psum_valid is honoured only while busy.
  - ch_cnt == 0: acc = sign-extended psum. Otherwise acc = acc + psum, wrapping at ACC_W.
  - On ch_cnt == groups-1, the pixel completes: acc value and bias are forwarded to stage 1 and ch_cnt returns to 0. Otherwise ch_cnt increments.
  - groups == 1: every beat completes a pixel.
  - Back-to-back beats with no gaps are supported; no backpressure exists.
- Stage 1: s1 = acc + bias, computed ACC_W+1 bits wide.
- Stage 2: p = s1 * scale (signed × unsigned).
- Stage 3:
  - r = (p + 2^(shift-1)) >>> shift (arithmetic shift).
  - Saturate r to [-128, 127]; any clipping sets sat_flag.
- Stage 4, activation on the int8 value x:
  - none: x.
  - ReLU: max(x, 0).
  - ReLU6: clamp(x, 0, SIX_Q).
  - hswish: t = clamp(x + SIX_Q/2, 0, SIX_Q); y = (x*t*INV_SIX + 2^15) >>> 16, saturated to int8.
- Latency: act_valid rises exactly 4 cycles after the completing psum_valid. act_data is stable only while act_valid is high and holds its last value otherwise.
- End of layer:
  - layer_end arms drain.
  - busy falls, and done pulses, on the cycle after the last in-flight result's act_valid. With nothing in flight this is the cycle after layer_end.
  - A partial pixel (ch_cnt ≠ 0) at layer_end is discarded.

Decomposition:
- Package point_pkg: act_mode encodings (ACT_NONE/RELU/RELU6/HSWISH), default LANES/PSUM_W/ACC_W/SIX_Q/INV_SIX, saturate-to-int8 function.
- Sub-module point_requant_lane: stages 1–4 for one lane, instantiated LANES times. Accumulator and control stay in the top.

Test Plan:
- groups=1, mode=none, scale=1, shift=1, bias=0, psum=+20 on all lanes -> act_valid 4 cycles later, all lanes 10.
- groups=3, psums 100, -30, 50 on lane 0, bias=20, scale=1, shift=2, ReLU -> lane 0 = 35; exactly one act_valid per 3 beats over 10 back-to-back pixels.
- Saturation: psum 5000, scale 1, shift 1, mode none -> +127 and sat_flag=1; psum -5000 -> -128; next start clears sat_flag.
- ReLU6 with x=120 -> 96; x=-5 -> 0. hswish with x=48 -> t=96, y=48; x=-48 -> 0; x=24 -> 18.
- Reset asserted 2 cycles after the last beat -> no act_valid, all outputs 0; start mid-pixel (ch_cnt=1) -> next beat treated as channel group 0.
- layer_end one cycle after the last completing beat -> act_valid 4 cycles after that beat, then done and busy low on the following cycle; layer_end with ch_cnt=2 -> partial pixel dropped.

Source files
------------

// File: rtl/point_pkg.sv
// Shared constants, activation encodings and int8 helpers for the pointwise
// accumulate / requantize / activation block.
package point_pkg;

    localparam int LANES   = 16;
    localparam int PSUM_W  = 24;
    localparam int ACC_W   = 32;
    localparam int BIAS_W  = 32;
    localparam int SIX_Q   = 96;
    localparam int INV_SIX = 683;

    localparam logic [1:0] ACT_NONE   = 2'd0;
    localparam logic [1:0] ACT_RELU   = 2'd1;
    localparam logic [1:0] ACT_RELU6  = 2'd2;
    localparam logic [1:0] ACT_HSWISH = 2'd3;

    // Clamp a wide signed value into the int8 range.
    function automatic logic signed [7:0] sat_int8(input logic signed [63:0] v);
        if (v > 64'sd127) begin
            return 8'sh7f;
        end
        if (v < -64'sd128) begin
            return 8'sh80;
        end
        return v[7:0];
    endfunction

    // True when sat_int8 would have to clip the value.
    function automatic logic clips_int8(input logic signed [63:0] v);
        return (v > 64'sd127) || (v < -64'sd128);
    endfunction

endpackage

// File: rtl/point_requant_lane.sv
// One output-filter lane: bias add, requant multiply, rounding shift with
// int8 saturation, then the selected activation. Valids live in the parent;
// each stage register only loads when its enable is high, so the output
// holds its last value between results.
module point_requant_lane
    import point_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_s1,
    input  logic              en_s2,
    input  logic              en_s3,
    input  logic              en_s4,
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [BIAS_W-1:0] bias_in,
    input  logic [15:0]       scale,
    input  logic [4:0]        shift,
    input  logic [1:0]        act_mode,
    output logic [7:0]        act_out,
    output logic              sat_out
);

    localparam int S1_W = ACC_W + 1;
    localparam int P_W  = S1_W + 17;
    localparam int R_W  = P_W + 1;

    localparam logic signed [7:0]  SIX8   = 8'(SIX_Q);
    localparam logic signed [9:0]  SIX10  = 10'(SIX_Q);
    localparam logic signed [9:0]  HALF10 = 10'(SIX_Q / 2);
    localparam logic signed [31:0] INV32  = 32'(INV_SIX);

    logic signed [S1_W-1:0] s1_d;
    logic signed [S1_W-1:0] s1_q;
    logic signed [P_W-1:0]  p_q;
    logic signed [R_W-1:0]  p_ext;
    logic signed [R_W-1:0]  rnd;
    logic signed [R_W-1:0]  r_d;
    logic signed [7:0]      s3_q;
    logic signed [7:0]      act_d;
    logic signed [9:0]      hs_x;
    logic signed [9:0]      hs_t;
    logic signed [31:0]     hs_prod;

    assign s1_d = S1_W'($signed(acc_in)) + S1_W'($signed(bias_in));

    // Stage 1: accumulator plus bias, one bit wider so the sum never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else if (en_s1) begin
            s1_q <= s1_d;
        end
    end

    // Stage 2: signed sum times the unsigned requant multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else if (en_s2) begin
            p_q <= P_W'(s1_q) * P_W'($signed({1'b0, scale}));
        end
    end

    // Round-half-up then arithmetic shift; a zero shift gets no rounding term.
    always_comb begin
        p_ext = R_W'(p_q);
        rnd   = '0;
        if (shift != 5'd0) begin
            rnd = R_W'(1) << (shift - 5'd1);
        end
        r_d = (p_ext + rnd) >>> shift;
    end

    // Stage 3: saturate to int8 and remember whether clipping happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_q    <= '0;
            sat_out <= 1'b0;
        end else if (en_s3) begin
            s3_q    <= sat_int8(64'(r_d));
            sat_out <= clips_int8(64'(r_d));
        end
    end

    // Activation on the int8 value; hswish uses x * clamp(x + 3, 0, 6) / 6.
    always_comb begin
        hs_x    = 10'(s3_q) + HALF10;
        hs_t    = hs_x;
        if (hs_x < 10'sd0) begin
            hs_t = 10'sd0;
        end else if (hs_x > SIX10) begin
            hs_t = SIX10;
        end
        hs_prod = 32'(s3_q) * 32'(hs_t) * INV32 + 32'sd32768;
        act_d   = s3_q;
        case (act_mode)
            ACT_NONE: begin
                act_d = s3_q;
            end
            ACT_RELU: begin
                act_d = s3_q[7] ? 8'sd0 : s3_q;
            end
            ACT_RELU6: begin
                if (s3_q < 8'sd0) begin
                    act_d = 8'sd0;
                end else if (s3_q > SIX8) begin
                    act_d = SIX8;
                end else begin
                    act_d = s3_q;
                end
            end
            default: begin
                act_d = sat_int8(64'(hs_prod >>> 16));
            end
        endcase
    end

    // Stage 4: register the activated result for the output bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_out <= '0;
        end else if (en_s4) begin
            act_out <= act_d;
        end
    end

endmodule

// File: rtl/point_accum_act.sv
// Pointwise accumulate + bias + requant + activation. Accumulates LANES
// partial sums over the configured channel groups, then pushes each finished
// pixel through a 4-stage per-lane pipeline. act_valid pulses once per pixel
// and feeds the address controller's activation_function_enable.
module point_accum_act
    import point_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              channel_groups,
    input  logic [1:0]              act_mode,
    input  logic [LANES*BIAS_W-1:0] bias_in,
    input  logic [15:0]             scale_in,
    input  logic [4:0]              shift_in,
    input  logic                    psum_valid,
    input  logic [LANES*PSUM_W-1:0] psum_in,
    input  logic                    layer_end,
    output logic                    act_valid,
    output logic [LANES*8-1:0]      act_data,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [3:0]       groups_q;
    logic [1:0]       mode_q;
    logic [15:0]      scale_q;
    logic [4:0]       shift_q;
    logic [3:0]       ch_cnt;
    logic             v1;
    logic             v2;
    logic             v3;
    logic             fire;
    logic             complete;
    logic             in_flight;
    logic [LANES-1:0] lane_sat;

    assign busy      = (state != ST_IDLE);
    assign fire      = psum_valid && (state == ST_RUN) && !start;
    assign complete  = fire && (ch_cnt == groups_q - 4'd1);
    assign in_flight = v1 || v2 || v3 || complete;

    // Configuration is captured only on start; a zero group count means one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            groups_q <= '0;
            mode_q   <= '0;
            scale_q  <= '0;
            shift_q  <= '0;
        end else if (start) begin
            groups_q <= (channel_groups == 4'd0) ? 4'd1 : channel_groups;
            mode_q   <= act_mode;
            scale_q  <= scale_in;
            shift_q  <= shift_in;
        end
    end

    // Channel-group counter; layer_end throws away any partial pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt <= '0;
        end else if (start) begin
            ch_cnt <= '0;
        end else begin
            if (fire) begin
                ch_cnt <= complete ? 4'd0 : ch_cnt + 4'd1;
            end
            if ((state == ST_RUN) && layer_end) begin
                ch_cnt <= '0;
            end
        end
    end

    // Run / drain control: done fires once nothing is left in the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state <= ST_RUN;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (layer_end) begin
                            if (in_flight) begin
                                state <= ST_DRAIN;
                            end else begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!(v1 || v2 || v3)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    // Pipeline valids; start flushes everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            act_valid <= 1'b0;
        end else if (start) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            act_valid <= 1'b0;
        end else begin
            v1        <= complete;
            v2        <= v1;
            v3        <= v2;
            act_valid <= v3;
        end
    end

    // Sticky saturation flag, cleared by start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (start) begin
            sat_flag <= 1'b0;
        end else if (v3 && (lane_sat != '0)) begin
            sat_flag <= 1'b1;
        end
    end

    genvar i;
    for (i = 0; i < LANES; i++) begin : g_lane
        logic signed [ACC_W-1:0] psum_ext;
        logic signed [ACC_W-1:0] acc_q;
        logic signed [ACC_W-1:0] acc_sum;

        assign psum_ext = ACC_W'($signed(psum_in[i*PSUM_W +: PSUM_W]));
        assign acc_sum  = (ch_cnt == 4'd0) ? psum_ext : acc_q + psum_ext;

        // Per-lane accumulator; the first group overwrites instead of adding.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
            end else if (fire) begin
                acc_q <= acc_sum;
            end
        end

        point_requant_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .en_s1    (complete),
            .en_s2    (v1 && !start),
            .en_s3    (v2 && !start),
            .en_s4    (v3 && !start),
            .acc_in   (acc_sum),
            .bias_in  (bias_in[i*BIAS_W +: BIAS_W]),
            .scale    (scale_q),
            .shift    (shift_q),
            .act_mode (mode_q),
            .act_out  (act_data[i*8 +: 8]),
            .sat_out  (lane_sat[i])
        );
    end

endmodule

// File: tb/tb_point_accum_act.sv
// Self-checking bench for point_accum_act: directed cases from the block's
// behaviour plus randomized layers, compared against an arithmetic model
// that predicts each pixel's value and the cycle its act_valid should appear.
module tb_point_accum_act;

    localparam int L = 16;

    typedef struct {
        int            cyc;
        logic [127:0]  data;
        bit            clip;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   channel_groups;
    logic [1:0]   act_mode;
    logic [511:0] bias_in;
    logic [15:0]  scale_in;
    logic [4:0]   shift_in;
    logic         psum_valid;
    logic [383:0] psum_in;
    logic         layer_end;
    logic         act_valid;
    logic [127:0] act_data;
    logic         busy;
    logic         done;
    logic         sat_flag;

    int   cycle = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   act_count = 0;

    int   m_groups, m_mode, m_scale, m_shift, m_cnt, m_last, m_start_cyc;
    int   m_acc [L];
    bit   m_sat;
    exp_t q [$];

    point_accum_act dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .channel_groups (channel_groups),
        .act_mode       (act_mode),
        .bias_in        (bias_in),
        .scale_in       (scale_in),
        .shift_in       (shift_in),
        .psum_valid     (psum_valid),
        .psum_in        (psum_in),
        .layer_end      (layer_end),
        .act_valid      (act_valid),
        .act_data       (act_data),
        .busy           (busy),
        .done           (done),
        .sat_flag       (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Count and report one comparison.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic for one lane of a finished pixel.
    function automatic int model_lane(input int acc, input int bias, input int mode,
                                      input int scale, input int shift, output bit clip);
        longint s1, p, r;
        int x, t, y;
        s1 = longint'(acc) + longint'(bias);
        p  = s1 * longint'(scale);
        r  = (p + (longint'(1) <<< (shift - 1))) >>> shift;
        clip = (r > 127) || (r < -128);
        x = (r > 127) ? 127 : ((r < -128) ? -128 : int'(r));
        case (mode)
            0: y = x;
            1: y = (x < 0) ? 0 : x;
            2: y = (x < 0) ? 0 : ((x > 96) ? 96 : x);
            default: begin
                t = x + 48;
                if (t < 0) t = 0;
                if (t > 96) t = 96;
                y = (x * t * 683 + 32768) >>> 16;
                if (y > 127) y = 127;
                if (y < -128) y = -128;
            end
        endcase
        return y;
    endfunction

    // Model one accepted beat; a finished pixel is queued 4 cycles ahead.
    task automatic model_beat(input int ps [L], input int bs [L]);
        exp_t e;
        bit   c;
        bit   anyc;
        int   y;
        for (int l = 0; l < L; l++) begin
            m_acc[l] = (m_cnt == 0) ? ps[l] : m_acc[l] + ps[l];
        end
        if (m_cnt == m_groups - 1) begin
            anyc   = 1'b0;
            e.data = '0;
            for (int l = 0; l < L; l++) begin
                y = model_lane(m_acc[l], bs[l], m_mode, m_scale, m_shift, c);
                e.data[l*8 +: 8] = 8'(y);
                anyc |= c;
            end
            e.cyc  = cycle + 4;
            e.clip = anyc;
            q.push_back(e);
            m_last = cycle;
            m_cnt  = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Compare every act_valid against the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (act_valid) begin
                act_count++;
                if (q.size() == 0) begin
                    checkOutput("act_spurious", act_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    checkOutput("act_cycle", cycle, e.cyc);
                    checkOutput("act_data", act_data, e.data);
                    if (e.cyc > m_start_cyc) m_sat |= e.clip;
                end
            end else if (q.size() > 0 && q[0].cyc <= cycle) begin
                checkOutput("act_missing", act_valid, 1'b1);
                void'(q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        start      = 1'b0;
        psum_valid = 1'b0;
        layer_end  = 1'b0;
    endtask

    task automatic do_start(input int g, input int mode, input int sc, input int sh);
        next_cycle();
        start          = 1'b1;
        channel_groups = 4'(g);
        act_mode       = 2'(mode);
        scale_in       = 16'(sc);
        shift_in       = 5'(sh);
        while (q.size() > 0 && q[$].cyc > cycle) void'(q.pop_back());
        m_groups    = (g == 0) ? 1 : g;
        m_mode      = mode;
        m_scale     = sc;
        m_shift     = sh;
        m_cnt       = 0;
        m_sat       = 1'b0;
        m_last      = -1000;
        m_start_cyc = cycle;
    endtask

    // Drive one partial-sum beat and feed the same data to the model.
    task automatic applyStimulus(input int ps [L], input int bs [L]);
        next_cycle();
        psum_valid = 1'b1;
        for (int l = 0; l < L; l++) begin
            psum_in[l*24 +: 24] = 24'(ps[l]);
            bias_in[l*32 +: 32] = 32'(bs[l]);
        end
        model_beat(ps, bs);
    endtask

    task automatic send_same(input int v, input int b);
        int ps [L];
        int bs [L];
        for (int l = 0; l < L; l++) begin
            ps[l] = v;
            bs[l] = b;
        end
        applyStimulus(ps, bs);
    endtask

    task automatic send_random();
        int ps [L];
        int bs [L];
        for (int l = 0; l < L; l++) begin
            ps[l] = int'($urandom_range(0, 8191)) - 4096;
            bs[l] = int'($urandom_range(0, 65535)) - 32768;
        end
        applyStimulus(ps, bs);
    endtask

    // Single pixel whose int8 value before activation is x (scale 1, shift 1).
    task automatic run_x(input string tag, input int mode, input int x, input int expv);
        logic [7:0] e8;
        e8 = 8'(expv);
        do_start(1, mode, 1, 1);
        send_same(2 * x, 0);
        repeat (6) next_cycle();
        checkOutput(tag, act_data, {16{e8}});
    endtask

    task automatic do_reset_mid();
        next_cycle();
        rst = 1'b1;
        q.delete();
        m_cnt  = 0;
        m_sat  = 1'b0;
        m_last = -1000;
        @(negedge clk);
        checkOutput("rst_act_valid", act_valid, 1'b0);
        checkOutput("rst_act_data", act_data, '0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_sat", sat_flag, 1'b0);
        next_cycle();
        rst = 1'b0;
    endtask

    // Pulse layer_end and check when done/busy settle.
    task automatic do_layer_end(input string tag);
        int lcyc;
        int exp_done;
        int got;
        next_cycle();
        layer_end = 1'b1;
        lcyc      = cycle;
        exp_done  = (m_last + 5 > lcyc + 1) ? m_last + 5 : lcyc + 1;
        m_cnt     = 0;
        next_cycle();
        got = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                got = cycle;
                break;
            end
        end
        checkOutput({tag, "_done_cycle"}, got, exp_done);
        checkOutput({tag, "_busy_low"}, busy, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, done, 1'b0);
        checkOutput({tag, "_drained"}, q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int g, mg, npix, part;
        rst            = 1'b1;
        start          = 1'b0;
        channel_groups = '0;
        act_mode       = '0;
        bias_in        = '0;
        scale_in       = '0;
        shift_in       = '0;
        psum_valid     = 1'b0;
        psum_in        = '0;
        layer_end      = 1'b0;
        m_groups = 1; m_mode = 0; m_scale = 0; m_shift = 1;
        m_cnt = 0; m_last = -1000; m_sat = 1'b0; m_start_cyc = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_act_valid", act_valid, 1'b0);
        checkOutput("reset_act_data", act_data, '0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_sat", sat_flag, 1'b0);
        next_cycle();
        rst = 1'b0;

        // Basic pass-through and busy after start.
        run_x("none_20", 0, 10, 10);
        checkOutput("busy_after_start", busy, 1'b1);

        // Three channel groups, ten back-to-back pixels.
        do_start(3, 1, 1, 2);
        c0 = act_count;
        for (int p = 0; p < 10; p++) begin
            send_same(100, 20);
            send_same(-30, 20);
            send_same(50, 20);
        end
        repeat (6) next_cycle();
        checkOutput("grp3_count", act_count - c0, 10);
        checkOutput("grp3_value", act_data, {16{8'd35}});

        // Saturation and its clearing on the next start.
        run_x("sat_pos", 0, 2500, 127);
        checkOutput("sat_set", sat_flag, 1'b1);
        run_x("sat_neg", 0, -2500, -128);
        checkOutput("sat_set_neg", sat_flag, 1'b1);
        do_start(1, 0, 1, 1);
        next_cycle();
        @(negedge clk);
        checkOutput("sat_cleared", sat_flag, 1'b0);

        // ReLU6 and hswish corner values.
        run_x("relu6_120", 2, 120, 96);
        run_x("relu6_neg5", 2, -5, 0);
        run_x("hswish_48", 3, 48, 48);
        run_x("hswish_neg48", 3, -48, 0);
        run_x("hswish_24", 3, 24, 18);

        // Reset two cycles after the last beat drops the pixel.
        do_start(1, 0, 1, 1);
        send_same(40, 0);
        next_cycle();
        c0 = act_count;
        do_reset_mid();
        repeat (6) next_cycle();
        checkOutput("rst_no_act", act_count - c0, 0);

        // Restart mid-pixel: the next beat is channel group 0 again.
        do_start(3, 0, 1, 1);
        send_same(1000, 0);
        do_start(3, 0, 1, 1);
        send_same(2, 0);
        send_same(4, 0);
        send_same(6, 0);
        repeat (6) next_cycle();
        checkOutput("restart_value", act_data, {16{8'd6}});

        // layer_end right after the completing beat, then with a partial pixel.
        do_start(1, 0, 1, 1);
        send_same(30, 0);
        do_layer_end("le_next");
        do_start(3, 0, 1, 1);
        c0 = act_count;
        send_same(10, 0);
        send_same(10, 0);
        do_layer_end("le_partial");
        checkOutput("le_partial_no_act", act_count - c0, 0);

        // Randomized layers.
        for (int ly = 0; ly < 8; ly++) begin
            g = (ly == 0) ? 0 : int'($urandom_range(1, 6));
            do_start(g, int'($urandom_range(0, 3)), int'($urandom_range(1, 4000)),
                     int'($urandom_range(8, 20)));
            mg   = m_groups;
            npix = int'($urandom_range(3, 8));
            for (int p = 0; p < npix; p++) begin
                for (int b = 0; b < mg; b++) begin
                    send_random();
                    if ($urandom_range(0, 3) == 0) next_cycle();
                end
            end
            if (mg > 1 && $urandom_range(0, 1) == 1) begin
                part = int'($urandom_range(1, mg - 1));
                for (int b = 0; b < part; b++) send_random();
            end
            repeat ($urandom_range(0, 5)) next_cycle();
            do_layer_end("layer");
            checkOutput("layer_sat", sat_flag, m_sat);
        end

        checkOutput("final_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
